// File: rtl/vae_stream_io_if.sv
// Valid/ready word stream between vae_stream_io and its neighbours.
//   valid : word present (driven by the producer)
//   ready : consumer accepts the word this cycle
//   data  : BITSIZE-bit word
//   last  : final word of a frame (producer side only)
// master = producer of words, slave = consumer of words.
interface vae_stream_io_if #(
  parameter int unsigned BITSIZE = 32
);
  logic               valid;
  logic               ready;
  logic [BITSIZE-1:0] data;
  logic               last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vae_stream_io.sv
// Streaming front/back end for the combinational VAE datapath.
// Collects N_IN words from the input stream into the flat vae_x bus, holds
// vae_x for SETTLE_CYCLES cycles, snapshots vae_y, then streams the M_OUT
// snapshot words out lane 0 first.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   s_if       : input word stream (slave side)
//   m_if       : output word stream (master side), last marks lane M_OUT-1
//   vae_x      : flat input bus to the datapath, lane i at [i*BITSIZE +: BITSIZE]
//   vae_y      : flat output bus from the datapath, same packing
//   frame_done : one-cycle pulse after the final output handshake
module vae_stream_io #(
  parameter int unsigned N_IN          = 9,
  parameter int unsigned M_OUT         = 9,
  parameter int unsigned BITSIZE       = 32,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  vae_stream_io_if.slave           s_if,
  vae_stream_io_if.master          m_if,
  output logic [N_IN*BITSIZE-1:0]  vae_x,
  input  logic [M_OUT*BITSIZE-1:0] vae_y,
  output logic                     frame_done
);

  localparam int unsigned IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int unsigned OW = (M_OUT > 1) ? $clog2(M_OUT) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } state_e;

  state_e                          state_q,      state_d;
  logic [IW-1:0]                   in_idx_q,     in_idx_d;
  logic [OW-1:0]                   out_idx_q,    out_idx_d;
  logic [CW-1:0]                   settle_cnt_q, settle_cnt_d;
  logic [N_IN-1:0][BITSIZE-1:0]    x_q,          x_d;
  logic [M_OUT-1:0][BITSIZE-1:0]   obuf_q,       obuf_d;
  logic                            s_ready_q,    s_ready_d;
  logic                            m_valid_q,    m_valid_d;
  logic [BITSIZE-1:0]              m_data_q,     m_data_d;
  logic                            m_last_q,     m_last_d;
  logic                            frame_done_q, frame_done_d;

  logic [M_OUT-1:0][BITSIZE-1:0]   y_lanes;
  logic [OW-1:0]                   out_nxt;

  assign y_lanes = vae_y;
  assign out_nxt = out_idx_q + OW'(1);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      settle_cnt_q <= '0;
      x_q          <= '0;
      obuf_q       <= '0;
      s_ready_q    <= 1'b1;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_idx_q     <= in_idx_d;
      out_idx_q    <= out_idx_d;
      settle_cnt_q <= settle_cnt_d;
      x_q          <= x_d;
      obuf_q       <= obuf_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    in_idx_d     = in_idx_q;
    out_idx_d    = out_idx_q;
    settle_cnt_d = settle_cnt_q;
    x_d          = x_q;
    obuf_d       = obuf_q;
    s_ready_d    = s_ready_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (s_if.valid && s_ready_q) begin
          x_d[in_idx_q] = s_if.data;
          if (in_idx_q == IW'(N_IN - 1)) begin
            in_idx_d     = '0;
            settle_cnt_d = '0;
            s_ready_d    = 1'b0;
            state_d      = SETTLE;
          end else begin
            in_idx_d = in_idx_q + IW'(1);
          end
        end
      end

      SETTLE: begin
        settle_cnt_d = settle_cnt_q + CW'(1);
        // Snapshot vae_y once the datapath has had its full settle budget;
        // lane 0 is preloaded so m_data is valid in the first SEND cycle.
        if (settle_cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          obuf_d    = y_lanes;
          m_valid_d = 1'b1;
          m_data_d  = y_lanes[0];
          m_last_d  = (M_OUT == 1);
          state_d   = SEND;
        end
      end

      SEND: begin
        // Without a handshake every output register holds its value.
        if (m_valid_q && m_if.ready) begin
          if (m_last_q) begin
            out_idx_d    = '0;
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
            frame_done_d = 1'b1;
            s_ready_d    = 1'b1;
            state_d      = LOAD;
          end else begin
            out_idx_d = out_nxt;
            m_data_d  = obuf_q[out_nxt];
            m_last_d  = (out_nxt == OW'(M_OUT - 1));
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign s_if.ready = s_ready_q;
  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign m_if.last  = m_last_q;
  assign vae_x      = x_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/vae_stream_io.md
Name: vae_stream_io

Overview:
- Sequential streaming front/back end for the combinational VAE datapath (encoder -> softplus -> sampling -> decoder -> sigmoid).
- Deserialises N_IN input words from a valid/ready stream into the flat parallel input bus.
- Holds that bus stable for a fixed settle window, then snapshots the flat sigmoid output bus.
- Serialises the M_OUT snapshot words back out on a valid/ready stream, lane 0 first.

Parameters:
N_IN, 9, number of input words per frame (VAE encoder input size)
M_OUT, 9, number of output words per frame (VAE decoder output size)
BITSIZE, 32, word width, fixed point: 1 sign, 4 integer, 27 fraction bits
SETTLE_CYCLES, 2, cycles vae_x is held before vae_y is sampled (multicycle path budget), legal range 1..15

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  input word valid
s_ready  out  1  block accepts input word
s_data  in  BITSIZE  input word
vae_x  out  N_IN*BITSIZE  flat input bus to VAE datapath; lane i at [i*BITSIZE +: BITSIZE]
vae_y  in  M_OUT*BITSIZE  flat sigmoid output bus from VAE datapath, same lane packing
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts output word
m_data  out  BITSIZE  output word
m_last  out  1  high with the final word (lane M_OUT-1) of a frame
frame_done  out  1  one-cycle pulse on the handshake of the final output word

Behaviour:
- FSM states: LOAD, SETTLE, SEND. All registers update on the clk edge.
- Reset (rst=1 at an edge), from any state including mid-frame:
  - state=LOAD; in_idx=0; out_idx=0; settle_cnt=0.
  - vae_x=0; output buffer=0; m_valid=0; m_last=0; frame_done=0.
  - s_ready=1 from the first cycle after reset deasserts.
  - Any partial frame is discarded. No output words are emitted for it.
- LOAD:
  - s_ready=1, m_valid=0.
  - On s_valid&&s_ready: s_data is written to vae_x lane in_idx, and in_idx increments.
  - s_valid gaps are allowed; in_idx holds during gaps.
  - On accepting lane N_IN-1: in_idx->0, settle_cnt->0, next state SETTLE.
- SETTLE:
  - s_ready=0, m_valid=0. vae_x is frozen.
  - settle_cnt increments each cycle.
  - In the cycle where settle_cnt==SETTLE_CYCLES-1, vae_y is registered into the output buffer and the next state is SEND.
- SEND:
  - m_valid=1, m_data=buffer lane out_idx, m_last=(out_idx==M_OUT-1).
  - m_data and m_valid must stay stable while m_ready=0.
  - Changes on vae_y during SEND have no effect.
  - On m_valid&&m_ready: out_idx increments.
  - On the final lane: out_idx->0, frame_done=1 for that cycle edge's following cycle, next state LOAD.
  - s_ready=0 throughout SEND. No input/output overlap.
- vae_x:
  - Holds its value through SEND and into the next LOAD.
  - Lanes are overwritten individually as new words arrive. There is no clearing between frames.
- Latency: last input handshake at edge T -> SETTLE for SETTLE_CYCLES cycles -> m_valid high in the cycle after edge T+SETTLE_CYCLES. For the default, that is the 3rd cycle after the last accept.
- Throughput: one frame per N_IN + SETTLE_CYCLES + M_OUT cycles minimum, i.e. 20 cycles at the defaults.
- Pure data movement: words are passed verbatim, with no arithmetic on word contents.

Test Plan:
- Reset then load: send s_data=0x00000001..0x00000009 back-to-back -> vae_x equals {0x9,0x8,...,0x1} (lane 0=0x1), and s_ready drops the cycle after the 9th accept.
- Settle/capture: vae_y stub = lane i holds 0x0400_0000+i, changed to 0xFFFF_FFFF one cycle after m_valid rises -> m_data sequence 0x04000000..0x04000008 unaffected; m_valid first high exactly 3 cycles after the last accept.
- Backpressure: m_ready low for 4 cycles while out_idx=4 -> m_data holds 0x04000004 and m_valid stays 1; m_last is high only on lane 8; frame_done pulses once.
- Input gaps: s_valid toggling 1,0,0,1,... across 9 words -> vae_x identical to the back-to-back case; in_idx unaffected by idle cycles.
- Reset mid-operation: assert rst during SEND at out_idx=3 -> next cycle m_valid=0, vae_x=0, s_ready=1. A fresh 9-word frame then yields its full 9-word output starting from lane 0.
- Two consecutive frames with SETTLE_CYCLES=1 -> second output frame reflects the second vae_y snapshot; s_ready is never high while m_valid is high.
